// File: rtl/uart_mult_frame_ctrl_pkg.sv
// Shared state encoding and constants for the UART frame controller and its multiplier.
package uart_mult_pkg;

  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam int         MUL_ITER = 8;

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_CK,
    MUL,
    TX_HI,
    TX_HI_BUSY,
    TX_HI_DONE,
    TX_LO,
    TX_LO_BUSY,
    TX_LO_DONE
  } uart_mult_state_t;

endpackage

// File: rtl/uart_mult_frame_ctrl_if.sv
// Receive/transmit byte handshake between the UART core and the frame controller.
interface uart_mult_frame_ctrl_if;

  logic [7:0] uart_received_data;
  logic       uart_rx_valid;
  logic       uart_tx_ready;
  logic [7:0] uart_transmit_data;
  logic       uart_tx_start;

  modport slave (
    input  uart_received_data,
    input  uart_rx_valid,
    input  uart_tx_ready,
    output uart_transmit_data,
    output uart_tx_start
  );

  modport master (
    output uart_received_data,
    output uart_rx_valid,
    output uart_tx_ready,
    input  uart_transmit_data,
    input  uart_tx_start
  );

endinterface

// File: rtl/uart_mult_frame_ctrl_shift_add_mult8.sv
// Sequential LSB-first shift-add multiplier; loads on start, pulses done after MUL_ITER iterations.
module shift_add_mult8
  import uart_mult_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result_o
);

  localparam logic [3:0] LAST = 4'(MUL_ITER - 1);

  logic [2*DATA_W-1:0] mcand_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [3:0]          cnt_q;
  logic                run_q;
  logic                done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        mcand_q  <= {{DATA_W{1'b0}}, a_i};
        mplier_q <= b_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done     = done_q;
  assign result_o = acc_q;

endmodule

// File: rtl/uart_mult_frame_ctrl.sv
// Frame controller: HEADER,A,B[,CK] in -> A*B out as hi/lo bytes. Optional checksum via UART_MULT_CHECKSUM_EN.
module uart_mult_frame_ctrl
  import uart_mult_pkg::*;
(
  input  logic                    clk_int,
  input  logic                    uart_reset,
  uart_mult_frame_ctrl_if.slave   bus,
  output logic [15:0]             product,
  output logic                    product_valid,
  output logic                    busy,
  output logic                    frame_err
);

  uart_mult_state_t state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] product_q, product_d;
  logic        pv_q, pv_d;
  logic        fe_q, fe_d;
  logic        err_q, err_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        mul_start, mul_done;
  logic [7:0]  mul_b;
  logic [15:0] mul_result;

  // Without a checksum the multiplier starts on the edge sampling B, before b_q is written.
  assign mul_b = (state_q == GET_B) ? bus.uart_received_data : b_q;

  shift_add_mult8 #(.DATA_W(8)) u_mult (
    .clk      (clk_int),
    .rst      (uart_reset),
    .start    (mul_start),
    .a_i      (a_q),
    .b_i      (mul_b),
    .done     (mul_done),
    .result_o (mul_result)
  );

  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      product_q  <= '0;
      pv_q       <= 1'b0;
      fe_q       <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      product_q  <= product_d;
      pv_q       <= pv_d;
      fe_q       <= fe_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    product_d  = product_q;
    pv_d       = 1'b0;
    fe_d       = 1'b0;
    err_d      = err_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    mul_start  = 1'b0;

    case (state_q)
      IDLE: if (bus.uart_rx_valid && bus.uart_received_data == HEADER) begin
        state_d = GET_A;
        err_d   = 1'b0;
      end
      GET_A: if (bus.uart_rx_valid) begin
        a_d     = bus.uart_received_data;
        state_d = GET_B;
      end
      GET_B: if (bus.uart_rx_valid) begin
        b_d = bus.uart_received_data;
`ifdef UART_MULT_CHECKSUM_EN
        state_d = GET_CK;
`else
        state_d   = MUL;
        mul_start = 1'b1;
`endif
      end
      GET_CK: begin
`ifdef UART_MULT_CHECKSUM_EN
        if (bus.uart_rx_valid) begin
          if (bus.uart_received_data == (a_q ^ b_q)) begin
            state_d   = MUL;
            mul_start = 1'b1;
          end else begin
            fe_d    = 1'b1;
            err_d   = 1'b1;
            state_d = TX_LO;
          end
        end
`else
        state_d = IDLE;
`endif
      end
      MUL: if (mul_done) begin
        product_d = mul_result;
        pv_d      = 1'b1;
        state_d   = TX_HI;
      end
      TX_HI:      if (tx_start_q)          state_d = TX_HI_BUSY;
      TX_HI_BUSY: if (!bus.uart_tx_ready)  state_d = TX_HI_DONE;
      TX_HI_DONE: if (bus.uart_tx_ready)   state_d = TX_LO;
      TX_LO:      if (tx_start_q)          state_d = TX_LO_BUSY;
      TX_LO_BUSY: if (!bus.uart_tx_ready)  state_d = TX_LO_DONE;
      TX_LO_DONE: if (bus.uart_tx_ready)   state_d = IDLE;
      default:                             state_d = IDLE;
    endcase

    // Start is registered from the edge entering (or waiting in) a TX state, so it lands in that state's cycle.
    if (!tx_start_q && bus.uart_tx_ready && (state_d == TX_HI || state_d == TX_LO)) begin
      tx_start_d = 1'b1;
      if (state_d == TX_HI)
        tx_data_d = product_d[15:8];
      else
        tx_data_d = err_d ? ERR_BYTE : product_d[7:0];
    end
  end

  assign bus.uart_transmit_data = tx_data_q;
  assign bus.uart_tx_start      = tx_start_q;
  assign product                = product_q;
  assign product_valid          = pv_q;
  assign busy                   = (state_q != IDLE);
  assign frame_err              = fe_q;

endmodule

// File: tb/tb_uart_mult_frame_ctrl.sv
// Directed bench for uart_mult_frame_ctrl with a simple transmitter model; checksum cases under UART_MULT_CHECKSUM_EN.
module tb_uart_mult_frame_ctrl;
  import uart_mult_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] product;
  logic        product_valid;
  logic        busy;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  int pv_cnt   = 0;
  int tx_busy  = 0;
  logic hold   = 1'b0;
  logic [7:0] tx_q[$];

  uart_mult_frame_ctrl_if bus();

  uart_mult_frame_ctrl dut (
    .clk_int       (clk),
    .uart_reset    (rst),
    .bus           (bus),
    .product       (product),
    .product_valid (product_valid),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: capture each started byte, stay not-ready for a few cycles.
  always @(negedge clk) begin
    if (product_valid) pv_cnt = pv_cnt + 1;
    if (rst) begin
      tx_busy = 0;
      bus.uart_tx_ready = 1'b1;
    end else if (bus.uart_tx_start) begin
      tx_q.push_back(bus.uart_transmit_data);
      bus.uart_tx_ready = 1'b0;
      tx_busy = 3;
    end else if (tx_busy > 0) begin
      tx_busy = tx_busy - 1;
      if (tx_busy == 0) bus.uart_tx_ready = !hold;
    end else begin
      bus.uart_tx_ready = !hold;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.uart_received_data = b;
    bus.uart_rx_valid      = 1'b1;
    @(negedge clk);
    bus.uart_rx_valid      = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 1'b0);
  endtask

  function automatic logic [15:0] tx_pair();
    logic [7:0] hi, lo;
    hi = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    lo = (tx_q.size() > 1) ? tx_q[1] : 8'h00;
    return {hi, lo};
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
    int n;
    int pv0;
    tx_q.delete();
    pv0 = pv_cnt;
    n   = 0;
    send_byte(HEADER);
    check({tag, "_busy_rise"}, busy, 1'b1);
    send_byte(a);
    send_byte(b);
`ifdef UART_MULT_CHECKSUM_EN
    send_byte(a ^ b);
`endif
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (product_valid) begin
        n = i;
        break;
      end
    end
    check({tag, "_latency"}, n, 9);
    check({tag, "_product"}, product, exp);
    check({tag, "_start_with_pv"}, bus.uart_tx_start, 1'b1);
    check({tag, "_hi_data"}, bus.uart_transmit_data, exp[15:8]);
    wait_idle({tag, "_idle"});
    check({tag, "_tx_count"}, tx_q.size(), 2);
    check({tag, "_tx_bytes"}, tx_pair(), exp);
    check({tag, "_pv_pulses"}, pv_cnt - pv0, 1);
  endtask

  initial begin
    rst                    = 1'b1;
    bus.uart_received_data = 8'h00;
    bus.uart_rx_valid      = 1'b0;
    bus.uart_tx_ready      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_product", product, 16'h0000);
    check("rst_pv", product_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", bus.uart_tx_start, 1'b0);
    check("rst_txdata", bus.uart_transmit_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame("f0c0d", 8'h0C, 8'h0D, 16'h009C);
    run_frame("fffff", 8'hFF, 8'hFF, 16'hFE01);

    send_byte(8'h33);
    check("junk_ignored", busy, 1'b0);
    run_frame("f0203", 8'h02, 8'h03, 16'h0006);

    // Transmitter stalled: result is computed but nothing is started; injected bytes are dropped.
    hold = 1'b1;
    tx_q.delete();
    send_byte(HEADER);
    send_byte(8'h04);
    send_byte(8'h05);
    repeat (12) @(negedge clk);
    check("hold_product", product, 16'h0014);
    send_byte(HEADER);
    send_byte(8'h07);
    send_byte(8'h07);
    repeat (32) @(negedge clk);
    check("hold_no_start", tx_q.size(), 0);
    check("hold_busy", busy, 1'b1);
    hold = 1'b0;
    wait_idle("hold_idle");
    check("hold_tx_bytes", tx_pair(), 16'h0014);
    check("hold_tx_count", tx_q.size(), 2);
    check("hold_drop", product, 16'h0014);
    run_frame("f110f", 8'h11, 8'h0F, 16'h00FF);

    // Reset in the middle of MUL.
    send_byte(HEADER);
    send_byte(8'h09);
    send_byte(8'h09);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_product", product, 16'h0000);
    check("midrst_pv", product_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_start", bus.uart_tx_start, 1'b0);
    check("midrst_txdata", bus.uart_transmit_data, 8'h00);
    check("midrst_ferr", frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame("f0202", 8'h02, 8'h02, 16'h0004);

`ifdef UART_MULT_CHECKSUM_EN
    run_frame("ck_ok", 8'h03, 8'h05, 16'h000F);
    begin
      int pv0;
      pv0 = pv_cnt;
      tx_q.delete();
      send_byte(HEADER);
      send_byte(8'h03);
      send_byte(8'h05);
      send_byte(8'h07);
      check("ck_bad_ferr", frame_err, 1'b1);
      wait_idle("ck_bad_idle");
      check("ck_bad_tx_count", tx_q.size(), 1);
      check("ck_bad_tx_byte", (tx_q.size() > 0) ? tx_q[0] : 8'h00, ERR_BYTE);
      check("ck_bad_product", product, 16'h000F);
      check("ck_bad_no_pv", pv_cnt - pv0, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
